bcd_converter_seq: RTL and testbench
====================================

# bcd_converter_seq

Sequential, parametrised binary-to-BCD converter with a per-digit seven-segment output stage. It generalises the combinational divide/modulo decoder to any input width N and any digit count DIGITS. It uses iterative shift-add-3 (double dabble), so no dividers are needed. A start/busy/done handshake is added, plus leading-zero blanking and an overflow flag. It sits between counter/switch logic and the board's seven-segment displays.

## Interface
- N, default 10: binary input width (N ≥ 1).
- DIGITS, default 4: number of BCD digits and displays (DIGITS ≥ 1).
- SEGMENTS, default 7: segments per display, bit order [0:SEGMENTS-1] = a..g, active-low.
- clk  in  1: single clock; everything is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: conversion request; honoured only in IDLE.
- bin_in  in  N: binary value, sampled on the accepting edge.
- blank_lz  in  1: leading-zero blanking enable, sampled together with bin_in.
- busy  out  1: high in SHIFT and DONE.
- done  out  1: one-cycle pulse when a result is valid.
- overflow  out  1: the last result was ≥ 10^DIGITS.
- bcd_out  out  4*DIGITS: result digits; digit k is at [4k+3:4k], digit 0 is the units digit.
- seg_out  out  DIGITS*SEGMENTS: glyph for digit k is at [SEGMENTS*k +: SEGMENTS].

## Operation
- Reset values: state IDLE, busy=0, done=0, overflow=0, bcd_out=0, blank register=0, so seg_out shows the "0" glyph on every digit.
- States:
  - IDLE: if start=1, capture bin_in into the shift register, clear the scratch BCD, counter=0, capture blank_lz, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch digit ≥ 5, then shift {scratch, shift register} left by 1 and increment the counter.
    - When a 1 is shifted out of the top digit, set the sticky overflow scratch bit.
    - After the Nth shift, load bcd_out and overflow from scratch and go to DONE.
  - DONE: done=1 for this cycle only, then go to IDLE unconditionally.
- start=1 outside IDLE is ignored, with no queuing.
- bcd_out, overflow and seg_out hold their last values until the next result is loaded.
- Overflow: bcd_out = bin_in mod 10^DIGITS; overflow=1.
- Counter width is $clog2(N+1).
- Digit adjust is 4-bit: +3 is applied only when the digit is ≥ 5, so a digit never exceeds 9 after a shift.
- Segment stage, per digit:
  - Decode the bcd_out digit to a glyph.
  - If the registered blank flag=1 and this digit and all higher digits are 0, drive SEG_BLANK (all ones) instead.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- seg_out is combinational from the registered bcd_out and blank flag, so it is glitch-free relative to clk.
- rst mid-conversion: abort, return to IDLE, clear outputs to the reset values, no done pulse.

## Timing
- Edge E0: start sampled high in IDLE; busy rises after E0.
- Edges E1..EN: the N shifts. At EN, bcd_out and overflow update and done rises.
- Edge E(N+1): done falls, busy falls, state is IDLE.
- The earliest next accepted start is at E(N+2), i.e. start held high from the IDLE cycle after done.
- Latency is N cycles from the accepting edge to valid bcd_out/done. Throughput is one conversion per N+2 cycles.
- seg_out follows bcd_out in the same cycle, with zero extra latency.

## Structure
- Shared package bcd_pkg holds:
  - Digit type (4 bits).
  - Per-digit BCD values 0–9.
  - SEG_BLANK (all segments off).
  - SEG_ZERO glyph (0000001).
  - State enum {IDLE, SHIFT, DONE}.
- Sub-module: decoder_7seg, reused unchanged and instantiated DIGITS times in a generate loop.
- The blanking mux and the leading-zero chain (computed from the most significant digit down) stay in the top level.

## Test plan
- N=10, DIGITS=4, bin_in=1023, start pulse: after 10 cycles done=1 for one cycle, bcd_out=0x1023, overflow=0, busy high for 11 cycles.
- bin_in=0, blank_lz=1: bcd_out=0x0000; digits 3..1 seg_out=SEG_BLANK; digit 0 shows the "0" glyph. Then 7 with blank_lz=1 blanks digits 3..1 only.
- N=14, DIGITS=4, bin_in=12345: bcd_out=0x2345, overflow=1. A following conversion of 9999 clears overflow to 0.
- start toggled every cycle during a conversion of 512: exactly one done pulse, bcd_out=0x0512, no second conversion started.
- rst asserted at shift 5 of a conversion of 999: next cycle busy=0, done=0, bcd_out=0, all digits show "0"; no done pulse afterwards.
- Back-to-back: sweep bin_in 0..1023 with start held high. Each done pulse is N+2 cycles apart and matches the reference model bin_in mod 10^DIGITS.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD converter and its display stage.
// Glyphs are active-low, bit order [0:6] = segments a..g.
package bcd_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_0 = 4'd0;
   localparam digit_t BCD_1 = 4'd1;
   localparam digit_t BCD_2 = 4'd2;
   localparam digit_t BCD_3 = 4'd3;
   localparam digit_t BCD_4 = 4'd4;
   localparam digit_t BCD_5 = 4'd5;
   localparam digit_t BCD_6 = 4'd6;
   localparam digit_t BCD_7 = 4'd7;
   localparam digit_t BCD_8 = 4'd8;
   localparam digit_t BCD_9 = 4'd9;

   localparam int SEG_W = 7;
   typedef logic [0:SEG_W-1] glyph_t;

   localparam glyph_t SEG_BLANK = 7'b1111111;
   localparam glyph_t SEG_ZERO  = 7'b0000001;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Pre-shift correction so a digit never exceeds 9 after doubling.
   function automatic digit_t addThree(input digit_t d);
      return (d >= BCD_5) ? digit_t'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Handshake and result bundle between the converter and its client logic.
interface bcd_converter_seq_if #(
   parameter int N        = 10,
   parameter int DIGITS   = 4,
   parameter int SEGMENTS = 7
);
   logic                         start;
   logic [N-1:0]                 bin_in;
   logic                         blank_lz;
   logic                         busy;
   logic                         done;
   logic                         overflow;
   logic [4*DIGITS-1:0]          bcd_out;
   logic [DIGITS*SEGMENTS-1:0]   seg_out;

   modport master (
      output start, bin_in, blank_lz,
      input  busy, done, overflow, bcd_out, seg_out
   );

   modport slave (
      input  start, bin_in, blank_lz,
      output busy, done, overflow, bcd_out, seg_out
   );
endinterface

// File: rtl/bcd_converter_seq_decoder.sv
// Single-digit BCD to active-low seven-segment glyph; codes above 9 show nothing.
module decoder_7seg
   import bcd_pkg::*;
(
   input  digit_t digit_i,
   output glyph_t seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         BCD_0:   seg_o = SEG_ZERO;
         BCD_1:   seg_o = 7'b1001111;
         BCD_2:   seg_o = 7'b0010010;
         BCD_3:   seg_o = 7'b0000110;
         BCD_4:   seg_o = 7'b1001100;
         BCD_5:   seg_o = 7'b0100100;
         BCD_6:   seg_o = 7'b0100000;
         BCD_7:   seg_o = 7'b0001111;
         BCD_8:   seg_o = 7'b0000000;
         BCD_9:   seg_o = 7'b0000100;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_converter_seq.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/done handshake,
// sticky overflow and a leading-zero-blanked seven-segment output per digit.
module bcd_converter_seq
   import bcd_pkg::*;
#(
   parameter int N        = 10,
   parameter int DIGITS   = 4,
   parameter int SEGMENTS = 7
) (
   input  logic                clk,
   input  logic                rst,
   bcd_converter_seq_if.slave  bus
);

   localparam int CW = $clog2(N + 1);
   localparam int BW = 4 * DIGITS;

   state_t          state_q, state_d;
   logic [N-1:0]    shift_q, shift_d;
   logic [BW-1:0]   scratch_q, scratch_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [BW-1:0]   adjusted;
   logic [CW-1:0]   count_q, count_d;
   logic            ovfScratch_q, ovfScratch_d;
   logic            ovf_q, ovf_d;
   logic            blankReq_q, blankReq_d;
   logic            blankDisp_q, blankDisp_d;
   logic [DIGITS-1:0]          lzMask;
   logic [DIGITS*SEGMENTS-1:0] segFlat;

   always_comb begin
      adjusted = '0;
      for (int k = 0; k < DIGITS; k++) begin
         adjusted[4*k +: 4] = addThree(scratch_q[4*k +: 4]);
      end
   end

   // The blank request is kept apart from the displayed flag so the display
   // holds its old appearance until the new result lands.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      scratch_d    = scratch_q;
      count_d      = count_q;
      ovfScratch_d = ovfScratch_q;
      ovf_d        = ovf_q;
      bcd_d        = bcd_q;
      blankReq_d   = blankReq_q;
      blankDisp_d  = blankDisp_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d      = bus.bin_in;
               scratch_d    = '0;
               ovfScratch_d = 1'b0;
               count_d      = '0;
               blankReq_d   = bus.blank_lz;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            shift_d      = shift_q << 1;
            scratch_d    = {adjusted[BW-2:0], shift_q[N-1]};
            ovfScratch_d = ovfScratch_q | adjusted[BW-1];
            count_d      = count_q + 1'b1;
            if (count_q == CW'(N - 1)) begin
               bcd_d       = scratch_d;
               ovf_d       = ovfScratch_d;
               blankDisp_d = blankReq_q;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         scratch_q    <= '0;
         count_q      <= '0;
         ovfScratch_q <= 1'b0;
         ovf_q        <= 1'b0;
         bcd_q        <= '0;
         blankReq_q   <= 1'b0;
         blankDisp_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         scratch_q    <= scratch_d;
         count_q      <= count_d;
         ovfScratch_q <= ovfScratch_d;
         ovf_q        <= ovf_d;
         bcd_q        <= bcd_d;
         blankReq_q   <= blankReq_d;
         blankDisp_q  <= blankDisp_d;
      end
   end

   // Walk from the most significant digit down; digit 0 is never a leading zero.
   always_comb begin
      logic allZero;
      allZero = 1'b1;
      lzMask  = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         allZero   = allZero & (bcd_q[4*k +: 4] == BCD_0);
         lzMask[k] = allZero && (k != 0);
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      glyph_t glyph;
      decoder_7seg u_dec (
         .digit_i (bcd_q[4*k +: 4]),
         .seg_o   (glyph)
      );
      assign segFlat[SEGMENTS*k +: SEGMENTS] = (blankDisp_q && lzMask[k]) ? SEG_BLANK : glyph;
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.overflow = ovf_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.seg_out  = segFlat;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: a 10-bit and a 14-bit instance, four digits each.
module tb_bcd_converter_seq;

   localparam logic [0:6] G0 = 7'b0000001;
   localparam logic [0:6] G1 = 7'b1001111;
   localparam logic [0:6] G2 = 7'b0010010;
   localparam logic [0:6] G3 = 7'b0000110;
   localparam logic [0:6] G5 = 7'b0100100;
   localparam logic [0:6] G7 = 7'b0001111;
   localparam logic [0:6] GB = 7'b1111111;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bcd_converter_seq_if #(.N(10), .DIGITS(4), .SEGMENTS(7)) busA ();
   bcd_converter_seq_if #(.N(14), .DIGITS(4), .SEGMENTS(7)) busB ();

   bcd_converter_seq #(.N(10), .DIGITS(4), .SEGMENTS(7)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   bcd_converter_seq #(.N(14), .DIGITS(4), .SEGMENTS(7)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Divide-based reference, only for the sweep.
   function automatic logic [15:0] refBcd(input int v);
      int r;
      r = v % 10000;
      return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
   endfunction

   // Starts one conversion on A; i counts cycles after the accepting edge.
   task automatic runA(input logic [9:0] v, input logic blank,
                       output int doneCnt, output int doneAt, output int busyCnt);
      tick();
      busA.start = 1'b1; busA.bin_in = v; busA.blank_lz = blank;
      tick();
      busA.start = 1'b0;
      doneCnt = 0; doneAt = -1; busyCnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (busA.busy) busyCnt++;
         if (busA.done) begin doneCnt++; doneAt = i; end
         tick();
      end
   endtask

   task automatic runB(input logic [13:0] v, output int doneCnt, output int doneAt);
      tick();
      busB.start = 1'b1; busB.bin_in = v; busB.blank_lz = 1'b0;
      tick();
      busB.start = 1'b0;
      doneCnt = 0; doneAt = -1;
      for (int i = 0; i < 18; i++) begin
         if (busB.done) begin doneCnt++; doneAt = i; end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      busA.start = 1'b0; busA.bin_in = '0; busA.blank_lz = 1'b0;
      busB.start = 1'b0; busB.bin_in = '0; busB.blank_lz = 1'b0;
      repeat (3) tick();
      checks++; if (busA.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busA.busy); end
      checks++; if (busA.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", busA.done); end
      checks++; if (busA.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b, expected 0", busA.overflow); end
      checks++; if (busA.bcd_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd: got %h, expected 0000", busA.bcd_out); end
      checks++; if (busA.seg_out !== {G0, G0, G0, G0}) begin errors++; $display("[TB] FAIL reset_seg: got %b, expected %b", busA.seg_out, {G0, G0, G0, G0}); end
      rst = 1'b0;
      tick();
      checks++; if (busA.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b, expected 0", busA.busy); end
   endtask

   task automatic test_max_value();
      int dc, da, bc;
      runA(10'd1023, 1'b0, dc, da, bc);
      checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL max_done_count: got %0d, expected 1", dc); end
      checks++; if (da !== 10) begin errors++; $display("[TB] FAIL max_latency: got %0d, expected 10", da); end
      checks++; if (bc !== 11) begin errors++; $display("[TB] FAIL max_busy_cycles: got %0d, expected 11", bc); end
      checks++; if (busA.bcd_out !== 16'h1023) begin errors++; $display("[TB] FAIL max_bcd: got %h, expected 1023", busA.bcd_out); end
      checks++; if (busA.overflow !== 1'b0) begin errors++; $display("[TB] FAIL max_ovf: got %b, expected 0", busA.overflow); end
      checks++; if (busA.seg_out !== {G1, G0, G2, G3}) begin errors++; $display("[TB] FAIL max_seg: got %b, expected %b", busA.seg_out, {G1, G0, G2, G3}); end
   endtask

   task automatic test_blanking();
      int dc, da, bc;
      runA(10'd0, 1'b1, dc, da, bc);
      checks++; if (busA.bcd_out !== 16'h0000) begin errors++; $display("[TB] FAIL blank0_bcd: got %h, expected 0000", busA.bcd_out); end
      checks++; if (busA.seg_out !== {GB, GB, GB, G0}) begin errors++; $display("[TB] FAIL blank0_seg: got %b, expected %b", busA.seg_out, {GB, GB, GB, G0}); end
      runA(10'd305, 1'b1, dc, da, bc);
      checks++; if (busA.seg_out !== {GB, G3, G0, G5}) begin errors++; $display("[TB] FAIL blank305_seg: got %b, expected %b", busA.seg_out, {GB, G3, G0, G5}); end
      runA(10'd7, 1'b1, dc, da, bc);
      checks++; if (busA.bcd_out !== 16'h0007) begin errors++; $display("[TB] FAIL blank7_bcd: got %h, expected 0007", busA.bcd_out); end
      checks++; if (busA.seg_out !== {GB, GB, GB, G7}) begin errors++; $display("[TB] FAIL blank7_seg: got %b, expected %b", busA.seg_out, {GB, GB, GB, G7}); end
   endtask

   task automatic test_start_ignored();
      int dc;
      tick();
      busA.start = 1'b1; busA.bin_in = 10'd512; busA.blank_lz = 1'b0;
      tick();
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 5) begin
            checks++; if (busA.bcd_out !== 16'h0007) begin errors++; $display("[TB] FAIL hold_bcd: got %h, expected 0007", busA.bcd_out); end
         end
         if (busA.done) dc++;
         if (i < 10) begin
            busA.start  = (i % 2 == 0);
            busA.bin_in = 10'd7;
         end else begin
            busA.start = 1'b0;
         end
         tick();
      end
      checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL ignore_done_count: got %0d, expected 1", dc); end
      checks++; if (busA.bcd_out !== 16'h0512) begin errors++; $display("[TB] FAIL ignore_bcd: got %h, expected 0512", busA.bcd_out); end
      checks++; if (busA.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_busy: got %b, expected 0", busA.busy); end
   endtask

   task automatic test_reset_mid();
      int dc;
      tick();
      busA.start = 1'b1; busA.bin_in = 10'd999; busA.blank_lz = 1'b1;
      tick();
      busA.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      checks++; if (busA.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, expected 0", busA.busy); end
      checks++; if (busA.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b, expected 0", busA.done); end
      checks++; if (busA.bcd_out !== 16'h0000) begin errors++; $display("[TB] FAIL abort_bcd: got %h, expected 0000", busA.bcd_out); end
      checks++; if (busA.seg_out !== {G0, G0, G0, G0}) begin errors++; $display("[TB] FAIL abort_seg: got %b, expected %b", busA.seg_out, {G0, G0, G0, G0}); end
      rst = 1'b0;
      dc = 0;
      for (int i = 0; i < 20; i++) begin
         if (busA.done) dc++;
         tick();
      end
      checks++; if (dc !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d, expected 0", dc); end
      checks++; if (busA.bcd_out !== 16'h0000) begin errors++; $display("[TB] FAIL abort_bcd_after: got %h, expected 0000", busA.bcd_out); end
   endtask

   task automatic test_overflow();
      int dc, da;
      runB(14'd12345, dc, da);
      checks++; if (da !== 14) begin errors++; $display("[TB] FAIL ovf_latency: got %0d, expected 14", da); end
      checks++; if (busB.bcd_out !== 16'h2345) begin errors++; $display("[TB] FAIL ovf12345_bcd: got %h, expected 2345", busB.bcd_out); end
      checks++; if (busB.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf12345_flag: got %b, expected 1", busB.overflow); end
      runB(14'd9999, dc, da);
      checks++; if (busB.bcd_out !== 16'h9999) begin errors++; $display("[TB] FAIL ovf9999_bcd: got %h, expected 9999", busB.bcd_out); end
      checks++; if (busB.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf9999_flag: got %b, expected 0", busB.overflow); end
      runB(14'd10000, dc, da);
      checks++; if (busB.bcd_out !== 16'h0000) begin errors++; $display("[TB] FAIL ovf10000_bcd: got %h, expected 0000", busB.bcd_out); end
      checks++; if (busB.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf10000_flag: got %b, expected 1", busB.overflow); end
      runB(14'd16383, dc, da);
      checks++; if (busB.bcd_out !== 16'h6383) begin errors++; $display("[TB] FAIL ovf16383_bcd: got %h, expected 6383", busB.bcd_out); end
   endtask

   task automatic test_back_to_back();
      int  waited;
      bit  ok;
      ok = 1'b1;
      tick();
      busA.bin_in = 10'd0; busA.blank_lz = 1'b0; busA.start = 1'b1;
      for (int v = 0; v < 1024 && ok; v++) begin
         waited = 0;
         do begin
            tick();
            waited++;
         end while (!busA.done && waited < 20);
         if (!busA.done) begin
            checks++; errors++; ok = 1'b0;
            $display("[TB] FAIL b2b_timeout: value %0d got no done within %0d cycles, expected %0d", v, waited, 12);
         end else begin
            if (v > 0) begin
               checks++; if (waited !== 12) begin errors++; $display("[TB] FAIL b2b_spacing: value %0d got %0d cycles, expected 12", v, waited); end
            end
            checks++; if (busA.bcd_out !== refBcd(v)) begin errors++; $display("[TB] FAIL b2b_bcd: value %0d got %h, expected %h", v, busA.bcd_out, refBcd(v)); end
            if (v < 1023) busA.bin_in = 10'(v + 1);
            else          busA.start = 1'b0;
         end
      end
      busA.start = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_max_value();
      test_blanking();
      test_start_ignored();
      test_reset_mid();
      test_overflow();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
